demux_1to4_reg: RTL and testbench
=================================

DEMUX_1TO4_REG -- requirements
Module: demux_1to4_reg

Interface
REQ-001 SHALL have parameter WIDTH, default 32, giving the data width of the input and of each output channel.
REQ-002 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-004 SHALL have port in_valid, input, 1 bit: the input word is valid.
REQ-005 SHALL have port in_ready, output, 1 bit: the block can accept the input word this cycle.
REQ-006 SHALL have port in_data, input, WIDTH bits: the input word.
REQ-007 SHALL have port in_sel, input, 2 bits: the destination channel, 0..3, qualified by in_valid.
REQ-008 SHALL have port out_valid, output, 4 bits: bit i means channel i holds a valid word.
REQ-009 SHALL have port out_ready, input, 4 bits: bit i means the consumer of channel i takes the word this cycle.
REQ-010 SHALL have ports out_data0..out_data3, output, WIDTH bits each: the held word of channels 0..3.
REQ-011 SHALL have ports cnt0..cnt3, output, 8 bits each: the number of words accepted per channel, modulo 256.

Function
REQ-012 SHALL provide one holding register and one valid flag per channel; out_dataN and out_valid[N] SHALL be driven directly from registers.
REQ-013 SHALL define accept = in_valid & in_ready.
REQ-014 SHALL define drain[i] = out_valid[i] & out_ready[i].
REQ-015 SHALL drive in_ready combinationally as !out_valid[in_sel] | out_ready[in_sel].
REQ-016 SHALL drive in_ready independently of in_valid, so in_ready may be high while in_valid is low.
REQ-017 SHALL, on accept, load in_data into channel in_sel, set out_valid[in_sel] the next cycle, and increment cnt[in_sel].
REQ-018 SHALL have a latency of exactly 1 cycle from accept to the word appearing on out_data.
REQ-019 SHALL, on drain[i] with no accept into channel i, clear out_valid[i] the next cycle and leave out_data i unchanged.
REQ-020 SHALL, on drain[i] and accept into channel i in the same cycle, keep out_valid[i] at 1 and load the new word, giving full throughput with no bubble.
REQ-021 SHALL, when out_valid[i] is 1 and out_ready[i] is 0, hold out_data i and out_valid[i] stable, and deassert in_ready for in_sel == i.
REQ-022 SHALL leave all other channels unaffected by a stall on channel i; they continue to accept and drain.
REQ-023 SHALL ignore in_data and in_sel when in_valid is 0, and SHALL NOT change any counter then.
REQ-024 SHALL wrap each counter from 255 to 0 on the next accept, with no saturation and no flag.
REQ-025 SHALL allow each channel to drain independently in the same cycle, up to 4 drains plus 1 accept per cycle.
REQ-026 SHALL NOT drop a word: a word is overwritten only in the same cycle it is drained.

Reset
REQ-027 SHALL, when rst is high at a clock edge, set out_valid to 4'b0000, out_data0..3 to 0 and cnt0..3 to 0.
REQ-028 SHALL give rst priority over a simultaneous accept or drain; a word presented in the reset cycle SHALL be discarded and not counted.
REQ-029 SHALL discard held words if rst is asserted mid-operation, and SHALL raise no out_valid in the cycle after reset.
REQ-030 SHALL hold in_ready at 1 for every in_sel after reset, since all channels are empty.

Verification
REQ-031 SHALL cover basic routing: after reset, in_valid=1, in_sel=2, in_data=32'h0000_000F for one cycle -> next cycle out_valid=4'b0100, out_data2=32'h0000_000F, cnt2=1, other counters 0.
REQ-032 SHALL cover a stall: channel 1 full with 32'h5 and out_ready[1]=0 -> with in_sel=1, in_ready=0 and out_data1 remains 32'h5 for 3 cycles; with in_sel=3, in_ready=1 and the word lands in channel 3.
REQ-033 SHALL cover simultaneous drain and fill: channel 0 holds 32'hC, out_ready[0]=1, and 32'h7 is accepted to channel 0 in the same cycle -> out_valid[0] stays 1, out_data0=32'h7, cnt0 increments by 1.
REQ-034 SHALL cover counter wrap: 256 consecutive accepts to channel 3 with out_ready=4'b1111 -> cnt3 reads 0, and after one more accept it reads 1.
REQ-035 SHALL cover reset mid-operation: all four channels full, then rst=1 together with an accept -> next cycle out_valid=0, all data 0, all counters 0, in_ready=1.
REQ-036 SHALL cover idle input: in_valid=0 with in_sel toggling 0..3 for 8 cycles -> out_valid and all counters unchanged.

Source files
------------

// File: rtl/demux_1to4_reg.sv
// demux_1to4_reg: routes one input word per cycle into one of four
// single-entry holding channels with valid/ready handshakes on both sides.
// Each channel keeps an 8-bit wrapping count of the words it has accepted.
module demux_1to4_reg #(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_data,
   input  logic [1:0]       in_sel,
   output logic [3:0]       out_valid,
   input  logic [3:0]       out_ready,
   output logic [WIDTH-1:0] out_data0,
   output logic [WIDTH-1:0] out_data1,
   output logic [WIDTH-1:0] out_data2,
   output logic [WIDTH-1:0] out_data3,
   output logic [7:0]       cnt0,
   output logic [7:0]       cnt1,
   output logic [7:0]       cnt2,
   output logic [7:0]       cnt3
);

   // Per-channel holding registers, valid flags and accept counters.
   logic [WIDTH-1:0] data_p1 [4];
   logic [3:0]       vld_p1;
   logic [7:0]       cnt_p1  [4];

   logic       accept;
   logic [3:0] load;
   logic [3:0] drain;

   // Counter step; wraps 255 -> 0 naturally in 8 bits.
   function automatic logic [7:0] cnt_inc(input logic [7:0] c);
      return c + 8'd1;
   endfunction

   // Handshake decode: a channel can take a word when empty or draining now.
   always_comb begin
      in_ready = ~vld_p1[in_sel] | out_ready[in_sel];
      accept   = in_valid & in_ready;
      load     = 4'b0000;
      if (accept) begin
         load[in_sel] = 1'b1;
      end
      drain    = vld_p1 & out_ready;
   end

   // Stage p1: load on accept, clear valid on drain without refill.
   always_ff @(posedge clk) begin
      if (rst) begin
         vld_p1 <= 4'b0000;
         for (int i = 0; i < 4; i++) begin
            data_p1[i] <= '0;
            cnt_p1[i]  <= 8'd0;
         end
      end else begin
         for (int i = 0; i < 4; i++) begin
            if (load[i]) begin
               data_p1[i] <= in_data;
               vld_p1[i]  <= 1'b1;
               cnt_p1[i]  <= cnt_inc(cnt_p1[i]);
            end else if (drain[i]) begin
               vld_p1[i]  <= 1'b0;
            end
         end
      end
   end

   assign out_valid = vld_p1;
   assign out_data0 = data_p1[0];
   assign out_data1 = data_p1[1];
   assign out_data2 = data_p1[2];
   assign out_data3 = data_p1[3];
   assign cnt0      = cnt_p1[0];
   assign cnt1      = cnt_p1[1];
   assign cnt2      = cnt_p1[2];
   assign cnt3      = cnt_p1[3];

endmodule

// File: tb/tb_demux_1to4_reg.sv
// Bench for demux_1to4_reg: directed vectors with literal expectations plus
// a queue-based channel model compared against the DUT every cycle.
module tb_demux_1to4_reg;

   localparam int WIDTH = 32;

   logic             clk;
   logic             rst;
   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] in_data;
   logic [1:0]       in_sel;
   logic [3:0]       out_valid;
   logic [3:0]       out_ready;
   logic [WIDTH-1:0] out_data0, out_data1, out_data2, out_data3;
   logic [7:0]       cnt0, cnt1, cnt2, cnt3;

   int n_chk  = 0;
   int n_fail = 0;

   demux_1to4_reg #(.WIDTH(WIDTH)) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_data   (in_data),
      .in_sel    (in_sel),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data0 (out_data0),
      .out_data1 (out_data1),
      .out_data2 (out_data2),
      .out_data3 (out_data3),
      .cnt0      (cnt0),
      .cnt1      (cnt1),
      .cnt2      (cnt2),
      .cnt3      (cnt3)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   // ---------------- behavioural model ----------------
   // Each channel is a queue of held words; it may never hold more than one.
   logic [WIDTH-1:0] mq [4][$];
   logic [WIDTH-1:0] m_last [4];
   int               m_cnt  [4];
   bit               model_on = 1'b0;

   function automatic logic m_ready(input logic [1:0] s, input logic [3:0] r);
      return (mq[s].size() == 0) || r[s];
   endfunction

   always @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < 4; i++) begin
            mq[i].delete();
            m_last[i] = '0;
            m_cnt[i]  = 0;
         end
         model_on = 1'b1;
      end else if (model_on) begin
         bit rdy;
         rdy = m_ready(in_sel, out_ready);
         for (int i = 0; i < 4; i++) begin
            if (mq[i].size() > 0 && out_ready[i]) void'(mq[i].pop_front());
         end
         if (in_valid && rdy) begin
            mq[in_sel].push_back(in_data);
            m_last[in_sel] = in_data;
            m_cnt[in_sel]  = (m_cnt[in_sel] + 1) % 256;
         end
      end
   end

   function automatic logic [3:0] m_valid();
      logic [3:0] v;
      for (int i = 0; i < 4; i++) v[i] = (mq[i].size() > 0);
      return v;
   endfunction

   // Compare process: every falling edge once the model has seen reset.
   always @(negedge clk) begin
      if (model_on && !rst) begin
         chk("m_out_valid", out_valid, m_valid());
         chk("m_in_ready",  in_ready,  m_ready(in_sel, out_ready));
         chk("m_out_data0", out_data0, m_last[0]);
         chk("m_out_data1", out_data1, m_last[1]);
         chk("m_out_data2", out_data2, m_last[2]);
         chk("m_out_data3", out_data3, m_last[3]);
         chk("m_cnt0", cnt0, m_cnt[0]);
         chk("m_cnt1", cnt1, m_cnt[1]);
         chk("m_cnt2", cnt2, m_cnt[2]);
         chk("m_cnt3", cnt3, m_cnt[3]);
      end
   end

   // ---------------- directed stimulus ----------------
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic send(input logic [1:0] s, input logic [WIDTH-1:0] d);
      in_valid = 1'b1;
      in_sel   = s;
      in_data  = d;
   endtask

   task automatic check_ready_all(input string nm, input logic exp);
      for (int s = 0; s < 4; s++) begin
         in_sel = s[1:0];
         #1;
         chk(nm, in_ready, exp);
      end
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      rst = 1'b1; in_valid = 1'b0; in_data = '0; in_sel = 2'd0; out_ready = 4'b0000;
      step(); step();
      rst = 1'b0;
      // reset state
      chk("rst_out_valid", out_valid, 4'b0000);
      chk("rst_cnt", {cnt0, cnt1, cnt2, cnt3}, 32'h0);
      chk("rst_data", {out_data0 | out_data1 | out_data2 | out_data3}, 32'h0);
      check_ready_all("rst_in_ready", 1'b1);

      // basic routing
      send(2'd2, 32'h0000_000F);
      step();
      in_valid = 1'b0;
      chk("route_valid", out_valid, 4'b0100);
      chk("route_data2", out_data2, 32'h0000_000F);
      chk("route_cnt2",  cnt2, 8'd1);
      chk("route_cnt_others", {cnt0, cnt1, cnt3}, 24'h0);
      out_ready = 4'b0100; step(); out_ready = 4'b0000;
      chk("drain2_valid", out_valid, 4'b0000);
      chk("drain2_data_kept", out_data2, 32'h0000_000F);

      // stall on channel 1, other channel proceeds
      send(2'd1, 32'h5); step();
      send(2'd1, 32'h9);
      #1 chk("stall_in_ready", in_ready, 1'b0);
      for (int k = 0; k < 3; k++) begin
         step();
         chk("stall_data1", out_data1, 32'h5);
         chk("stall_valid1", out_valid[1], 1'b1);
      end
      chk("stall_cnt1", cnt1, 8'd1);
      send(2'd3, 32'h33);
      #1 chk("bypass_in_ready", in_ready, 1'b1);
      step();
      in_valid = 1'b0;
      chk("bypass_data3", out_data3, 32'h33);
      chk("bypass_valid", out_valid, 4'b1010);

      // simultaneous drain and fill on channel 0
      send(2'd0, 32'hC); step();
      chk("fill0_data", out_data0, 32'hC);
      out_ready = 4'b0001;
      send(2'd0, 32'h7);
      #1 chk("df_in_ready", in_ready, 1'b1);
      step();
      in_valid = 1'b0; out_ready = 4'b0000;
      chk("df_valid0", out_valid[0], 1'b1);
      chk("df_data0", out_data0, 32'h7);
      chk("df_cnt0", cnt0, 8'd2);

      // idle input with in_sel toggling
      for (int k = 0; k < 8; k++) begin
         in_valid = 1'b0; in_sel = k[1:0]; in_data = 32'hDEAD_0000 + k;
         step();
         chk("idle_valid", out_valid, 4'b1011);
         chk("idle_cnt", {cnt0, cnt1, cnt2, cnt3}, {8'd2, 8'd1, 8'd1, 8'd1});
      end
      out_ready = 4'b1111; step(); out_ready = 4'b0000;
      chk("drain_all", out_valid, 4'b0000);

      // counter wrap on channel 3 from a fresh reset
      rst = 1'b1; step(); rst = 1'b0;
      out_ready = 4'b1111;
      for (int k = 0; k < 256; k++) begin
         send(2'd3, k);
         step();
      end
      chk("wrap_cnt3", cnt3, 8'd0);
      chk("wrap_data3", out_data3, 32'd255);
      send(2'd3, 32'h100); step();
      chk("wrap_cnt3_plus1", cnt3, 8'd1);
      in_valid = 1'b0; step();

      // reset mid-operation with all channels full
      out_ready = 4'b0000;
      for (int k = 0; k < 4; k++) begin
         send(k[1:0], 32'hA0 + k);
         step();
      end
      chk("full_valid", out_valid, 4'b1111);
      send(2'd0, 32'hBB);
      #1 chk("full_in_ready", in_ready, 1'b0);
      rst = 1'b1; out_ready = 4'b1111;
      step();
      rst = 1'b0; in_valid = 1'b0; out_ready = 4'b0000;
      chk("mid_rst_valid", out_valid, 4'b0000);
      chk("mid_rst_data", {out_data0, out_data1, out_data2, out_data3}, 128'h0);
      chk("mid_rst_cnt", {cnt0, cnt1, cnt2, cnt3}, 32'h0);
      check_ready_all("mid_rst_in_ready", 1'b1);
      step();
      chk("post_rst_valid", out_valid, 4'b0000);

      // mixed traffic checked by the model
      for (int k = 0; k < 300; k++) begin
         in_valid  = $urandom_range(0, 1);
         in_sel    = $urandom_range(0, 3);
         in_data   = $urandom;
         out_ready = $urandom_range(0, 15);
         step();
      end
      in_valid = 1'b0;
      step();

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
